// File: rtl/game_pkg.sv
// Shared encodings for the maze game: game_status codes, player_status codes
// and the game-progress state type. Also imported by Scrolls, Obstacles and VideoController.
package game_pkg;

    typedef enum logic [2:0] {
        GS_START     = 3'd0,
        GS_PLAYING   = 3'd1,
        GS_LEVEL_INC = 3'd2,
        GS_WORLD_INC = 3'd3,
        GS_LIFE_LOST = 3'd4,
        GS_LOSE      = 3'd5,
        GS_WIN       = 3'd6
    } game_state_t;

    localparam logic [1:0] PS_PLAYING = 2'd0;
    localparam logic [1:0] PS_PASSED  = 2'd1;
    localparam logic [1:0] PS_DIED    = 2'd2;

    localparam int HOLD_W = 32;

    // The reserved player_status code behaves exactly like "playing".
    function automatic logic [1:0] ps_normalize(input logic [1:0] ps);
        return (ps == 2'd3) ? PS_PLAYING : ps;
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer for an asynchronous pushbutton followed by a
// rising-edge detector; pulse is high for one cycle per press.
module btn_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    logic [1:0] sync_reg;
    logic       prev_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_reg <= 2'b00;
            prev_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[0], btn};
            prev_reg <= sync_reg[1];
        end
    end

    assign pulse = sync_reg[1] & ~prev_reg;

endmodule

// File: rtl/game_state_fsm.sv
// Game-progress controller: tracks lives, level and world and drives game_status.
// Optional feature macro GAME_FSM_EXTRA_LIFE_EN: a world advance grants one life, capped at MAX_LIVES.
module game_state_fsm
    import game_pkg::*;
#(
    parameter int LEVELS_PER_WORLD = 4,
    parameter int NUM_WORLDS       = 3,
    parameter int START_LIVES      = 3,
    parameter int MAX_LIVES        = 9,
    parameter int HOLD_CYCLES      = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_btn,
    input  logic [1:0] player_status,
    output logic [2:0] game_status,
    output logic [1:0] world,
    output logic [2:0] level,
    output logic [3:0] lives
);

    localparam logic [2:0]        LAST_LEVEL = 3'(LEVELS_PER_WORLD - 1);
    localparam logic [1:0]        LAST_WORLD = 2'(NUM_WORLDS - 1);
    localparam logic [3:0]        INIT_LIVES = 4'(START_LIVES);
    localparam logic [HOLD_W-1:0] HOLD_LOAD  = HOLD_W'(HOLD_CYCLES - 1);
`ifdef GAME_FSM_EXTRA_LIFE_EN
    localparam logic [3:0]        CAP_LIVES  = 4'(MAX_LIVES);
`endif

    game_state_t       state_reg, state_next;
    logic [2:0]        level_reg, level_next;
    logic [1:0]        world_reg, world_next;
    logic [3:0]        lives_reg, lives_next;
    logic [HOLD_W-1:0] hold_reg,  hold_next;
    logic              start_pulse;
    logic [1:0]        ps;

    btn_sync_edge u_start (
        .clk   (clk),
        .rst   (rst),
        .btn   (start_btn),
        .pulse (start_pulse)
    );

    assign ps = ps_normalize(player_status);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= GS_START;
            level_reg <= 3'd0;
            world_reg <= 2'd0;
            lives_reg <= INIT_LIVES;
            hold_reg  <= '0;
        end else begin
            state_reg <= state_next;
            level_reg <= level_next;
            world_reg <= world_next;
            lives_reg <= lives_next;
            hold_reg  <= hold_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        level_next = level_reg;
        world_next = world_reg;
        lives_next = lives_reg;
        hold_next  = hold_reg;

        case (state_reg)
            GS_START, GS_LOSE, GS_WIN: begin
                if (start_pulse) begin
                    state_next = GS_PLAYING;
                    level_next = 3'd0;
                    world_next = 2'd0;
                    lives_next = INIT_LIVES;
                end
            end

            GS_PLAYING: begin
                if (ps == PS_PASSED) begin
                    if (level_reg < LAST_LEVEL) begin
                        state_next = GS_LEVEL_INC;
                        level_next = level_reg + 3'd1;
                        hold_next  = HOLD_LOAD;
                    end else if (world_reg < LAST_WORLD) begin
                        state_next = GS_WORLD_INC;
                        level_next = 3'd0;
                        world_next = world_reg + 2'd1;
                        hold_next  = HOLD_LOAD;
`ifdef GAME_FSM_EXTRA_LIFE_EN
                        lives_next = (lives_reg >= CAP_LIVES) ? lives_reg : lives_reg + 4'd1;
`else
                        lives_next = lives_reg;
`endif
                    end else begin
                        state_next = GS_WIN;
                    end
                end else if (ps == PS_DIED) begin
                    if (lives_reg > 4'd1) begin
                        state_next = GS_LIFE_LOST;
                        lives_next = lives_reg - 4'd1;
                        hold_next  = HOLD_LOAD;
                    end else begin
                        state_next = GS_LOSE;
                        lives_next = 4'd0;
                    end
                end
            end

            // Expiry only releases once the play logic drops its status, so a
            // long status pulse cannot trigger a second advance.
            GS_LEVEL_INC, GS_WORLD_INC, GS_LIFE_LOST: begin
                if (hold_reg == '0) begin
                    if (ps == PS_PLAYING) begin
                        state_next = GS_PLAYING;
                    end
                end else begin
                    hold_next = hold_reg - 1'b1;
                end
            end

            default: state_next = GS_START;
        endcase
    end

    assign game_status = state_reg;
    assign level       = level_reg;
    assign world       = world_reg;
    assign lives       = lives_reg;

endmodule

// File: tb/tb_game_state_fsm.sv
// Self-checking bench for game_state_fsm with HOLD_CYCLES=4: scenario tasks
// push expected snapshots to a scoreboard and pop/compare them as the DUT updates.
module tb_game_state_fsm;
    import game_pkg::*;

    localparam int HOLD = 4;
    localparam int LIVES0 = 3;
    localparam int LIVES_CAP = 9;

    typedef struct packed {
        logic [2:0] st;
        logic [2:0] lvl;
        logic [1:0] wld;
        logic [3:0] lv;
    } snap_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start_btn = 1'b0;
    logic [1:0] player_status = 2'd0;
    logic [2:0] game_status;
    logic [1:0] world;
    logic [2:0] level;
    logic [3:0] lives;

    snap_t sb[$];
    int    tests = 0;
    int    fails = 0;
    int    lives_exp = LIVES0;

    game_state_fsm #(
        .LEVELS_PER_WORLD (4),
        .NUM_WORLDS       (3),
        .START_LIVES      (LIVES0),
        .MAX_LIVES        (LIVES_CAP),
        .HOLD_CYCLES      (HOLD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start_btn     (start_btn),
        .player_status (player_status),
        .game_status   (game_status),
        .world         (world),
        .level         (level),
        .lives         (lives)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time budget expired, got no summary, want summary");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_snap(input int st, input int lvl, input int w, input int lv);
        snap_t e;
        e.st  = 3'(st);
        e.lvl = 3'(lvl);
        e.wld = 2'(w);
        e.lv  = 4'(lv);
        sb.push_back(e);
    endtask

    function automatic snap_t observe();
        snap_t o;
        o.st  = game_status;
        o.lvl = level;
        o.wld = world;
        o.lv  = lives;
        return o;
    endfunction

    task automatic test_reset();
        snap_t got, exp;
        rst = 1'b0;
        repeat (3) tick();
        expect_snap(GS_START, 0, 0, LIVES0);
        got = observe(); exp = sb.pop_front(); tests++;
        if (got !== exp) begin fails++; $display("FAIL reset_hold got st/lvl/w/lv=%p want=%p", got, exp); end
        else $display("[TB] reset_hold st=%0d lives=%0d", got.st, got.lv);
        rst = 1'b1;
        tick();
        expect_snap(GS_START, 0, 0, LIVES0);
        got = observe(); exp = sb.pop_front(); tests++;
        if (got !== exp) begin fails++; $display("FAIL reset_idle got=%p want=%p", got, exp); end
        else $display("[TB] reset_idle st=%0d", got.st);
    endtask

    // Raise start_btn before "edge 1"; PLAYING must appear only after edge 3.
    task automatic press_start(input string name, input int st, input int lvl, input int w, input int lv);
        snap_t got, exp;
        start_btn = 1'b1;
        tick();
        tick();
        expect_snap(st, lvl, w, lv);
        got = observe(); exp = sb.pop_front(); tests++;
        if (got !== exp) begin fails++; $display("FAIL %s_edge2 got=%p want=%p", name, got, exp); end
        else $display("[TB] %s_edge2 st=%0d", name, got.st);
        tick();
        expect_snap(GS_PLAYING, 0, 0, LIVES0);
        got = observe(); exp = sb.pop_front(); tests++;
        if (got !== exp) begin fails++; $display("FAIL %s_edge3 got=%p want=%p", name, got, exp); end
        else $display("[TB] %s_edge3 st=%0d lvl=%0d w=%0d lives=%0d", name, got.st, got.lvl, got.wld, got.lv);
        start_btn = 1'b0;
        repeat (3) tick();
    endtask

    // One-cycle player_status pulse, then (for transition states) check the exact hold length.
    task automatic do_event(input string name, input int psv, input int st, input int lvl, input int w, input int lv);
        snap_t got, exp;
        player_status = 2'(psv);
        tick();
        player_status = 2'd0;
        expect_snap(st, lvl, w, lv);
        got = observe(); exp = sb.pop_front(); tests++;
        if (got !== exp) begin fails++; $display("FAIL %s_enter got=%p want=%p", name, got, exp); end
        else $display("[TB] %s_enter st=%0d lvl=%0d w=%0d lives=%0d", name, got.st, got.lvl, got.wld, got.lv);
        if (st == GS_LEVEL_INC || st == GS_WORLD_INC || st == GS_LIFE_LOST) begin
            repeat (HOLD - 1) tick();
            expect_snap(st, lvl, w, lv);
            got = observe(); exp = sb.pop_front(); tests++;
            if (got !== exp) begin fails++; $display("FAIL %s_hold got=%p want=%p", name, got, exp); end
            tick();
            expect_snap(GS_PLAYING, lvl, w, lv);
            got = observe(); exp = sb.pop_front(); tests++;
            if (got !== exp) begin fails++; $display("FAIL %s_resume got=%p want=%p", name, got, exp); end
            else $display("[TB] %s_resume after %0d cycles", name, HOLD);
        end
    endtask

    task automatic test_level_advance();
        do_event("level_adv", PS_PASSED, GS_LEVEL_INC, 1, 0, LIVES0);
    endtask

    task automatic test_last_level();
        snap_t got, exp;
        lives_exp = LIVES0;
        do_event("lvl2", PS_PASSED, GS_LEVEL_INC, 2, 0, lives_exp);
        do_event("lvl3", PS_PASSED, GS_LEVEL_INC, 3, 0, lives_exp);
        for (int w = 1; w <= 2; w++) begin
`ifdef GAME_FSM_EXTRA_LIFE_EN
            if (lives_exp < LIVES_CAP) lives_exp++;
`endif
            do_event("world_inc", PS_PASSED, GS_WORLD_INC, 0, w, lives_exp);
            for (int l = 1; l <= 3; l++) do_event("lvl_in_world", PS_PASSED, GS_LEVEL_INC, l, w, lives_exp);
        end
        do_event("win", PS_PASSED, GS_WIN, 3, 2, lives_exp);
        player_status = PS_DIED;
        tick();
        player_status = PS_PASSED;
        tick();
        player_status = 2'd0;
        tick();
        expect_snap(GS_WIN, 3, 2, lives_exp);
        got = observe(); exp = sb.pop_front(); tests++;
        if (got !== exp) begin fails++; $display("FAIL win_frozen got=%p want=%p", got, exp); end
        else $display("[TB] win_frozen st=%0d", got.st);
        press_start("restart_win", GS_WIN, 3, 2, lives_exp);
    endtask

    task automatic test_deaths();
        snap_t got, exp;
        do_event("death1", PS_DIED, GS_LIFE_LOST, 0, 0, 2);
        do_event("death2", PS_DIED, GS_LIFE_LOST, 0, 0, 1);
        do_event("death3", PS_DIED, GS_LOSE, 0, 0, 0);
        repeat (2) tick();
        expect_snap(GS_LOSE, 0, 0, 0);
        got = observe(); exp = sb.pop_front(); tests++;
        if (got !== exp) begin fails++; $display("FAIL lose_stays got=%p want=%p", got, exp); end
        press_start("restart_lose", GS_LOSE, 0, 0, 0);
    endtask

    task automatic test_held_status();
        snap_t got, exp;
        player_status = PS_PASSED;
        for (int c = 0; c < 10; c++) begin
            tick();
            expect_snap(GS_LEVEL_INC, 1, 0, LIVES0);
            got = observe(); exp = sb.pop_front(); tests++;
            if (got !== exp) begin fails++; $display("FAIL held_cycle%0d got=%p want=%p", c, got, exp); end
        end
        player_status = 2'd0;
        tick();
        expect_snap(GS_PLAYING, 1, 0, LIVES0);
        got = observe(); exp = sb.pop_front(); tests++;
        if (got !== exp) begin fails++; $display("FAIL held_release got=%p want=%p", got, exp); end
        else $display("[TB] held_release st=%0d lvl=%0d", got.st, got.lvl);
        player_status = 2'd3;
        repeat (2) tick();
        player_status = 2'd0;
        expect_snap(GS_PLAYING, 1, 0, LIVES0);
        got = observe(); exp = sb.pop_front(); tests++;
        if (got !== exp) begin fails++; $display("FAIL reserved_status got=%p want=%p", got, exp); end
    endtask

    task automatic test_reset_mid();
        snap_t got, exp;
        player_status = PS_PASSED;
        tick();
        player_status = 2'd0;
        tick();
        #2;
        rst = 1'b0;
        #1;
        expect_snap(GS_START, 0, 0, LIVES0);
        got = observe(); exp = sb.pop_front(); tests++;
        if (got !== exp) begin fails++; $display("FAIL reset_async got=%p want=%p", got, exp); end
        else $display("[TB] reset_async st=%0d lvl=%0d", got.st, got.lvl);
        tick();
        rst = 1'b1;
        tick();
        expect_snap(GS_START, 0, 0, LIVES0);
        got = observe(); exp = sb.pop_front(); tests++;
        if (got !== exp) begin fails++; $display("FAIL reset_release got=%p want=%p", got, exp); end
        press_start("start_after_reset", GS_START, 0, 0, LIVES0);
        do_event("post_reset_adv", PS_PASSED, GS_LEVEL_INC, 1, 0, LIVES0);
    endtask

    initial begin
        test_reset();
        press_start("start", GS_START, 0, 0, LIVES0);
        test_level_advance();
        test_last_level();
        test_deaths();
        test_held_status();
        test_reset_mid();
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain got=%0d leftover want=0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
